// File: rtl/branch_predict_unit.sv
// Branch prediction (direct-mapped BTB + 2-bit BHT) and decode-stage
// branch resolution with registered redirect and statistics counters.
module branch_predict_unit #(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  input  logic             de_en,
  input  logic [31:0]      de_pc,
  input  logic [31:0]      de_instruction,
  input  logic             de_is_branch,
  input  logic [2:0]       de_branch_type,
  input  logic [31:0]      de_data_rs,
  input  logic [31:0]      de_data_rt,
  input  logic             de_pred_taken,
  input  logic [31:0]      de_pred_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [2:0] B_EQNE = 3'd1;
  localparam logic [2:0] B_LTGE = 3'd2;
  localparam logic [2:0] B_JUMP = 3'd3;
  localparam logic [2:0] B_JREG = 3'd4;

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  logic [1:0]       bht        [BHT_N];
  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];
  logic [BTB_N-1:0] btb_uncond;

  logic [BHT_IDX_W-1:0] if_bidx;
  logic [BTB_IDX_W-1:0] if_tidx;
  logic [TAG_W-1:0]     if_tag;
  logic                 if_hit;

  assign if_bidx = if_pc[BHT_IDX_W+1:2];
  assign if_tidx = if_pc[BTB_IDX_W+1:2];
  assign if_tag  = if_pc[31:BTB_IDX_W+2];
  assign if_hit  = btb_valid[if_tidx]
                && (btb_tag[if_tidx] == if_tag);

  assign if_pred_taken = if_hit
    && (btb_uncond[if_tidx] || bht[if_bidx][1]);
  assign if_pred_target = if_pred_taken
    ? btb_target[if_tidx] : 32'h0;

  logic [BHT_IDX_W-1:0] de_bidx;
  logic [BTB_IDX_W-1:0] de_tidx;
  logic [TAG_W-1:0]     de_tag;
  logic [31:0]          pc4;
  logic [31:0]          br_target;
  logic [31:0]          j_target;
  logic [15:0]          imm;
  logic                 rs_neg;
  logic                 rs_zero;
  logic                 act_taken;
  logic [31:0]          act_target;
  logic                 act_uncond;
  logic                 mispredict;
  logic [31:0]          correct_pc;
  logic                 qual;
  logic [1:0]           bht_cur;
  logic [1:0]           bht_next;

  assign de_bidx   = de_pc[BHT_IDX_W+1:2];
  assign de_tidx   = de_pc[BTB_IDX_W+1:2];
  assign de_tag    = de_pc[31:BTB_IDX_W+2];
  assign imm       = de_instruction[15:0];
  assign pc4       = de_pc + 32'd4;
  assign br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {pc4[31:28], de_instruction[25:0], 2'b00};
  assign rs_neg    = de_data_rs[31];
  assign rs_zero   = (de_data_rs == 32'h0);
  assign qual      = de_en && de_is_branch;

  always_comb begin
    act_taken  = 1'b0;
    act_target = br_target;
    act_uncond = 1'b0;
    unique case (1'b1)
      (de_branch_type == B_EQNE): begin
        case (de_instruction[27:26])
          2'b00:   act_taken = (de_data_rs == de_data_rt);
          2'b01:   act_taken = (de_data_rs != de_data_rt);
          2'b10:   act_taken = rs_neg || rs_zero;
          default: act_taken = !rs_neg && !rs_zero;
        endcase
      end
      (de_branch_type == B_LTGE): begin
        act_taken = de_instruction[16] ? !rs_neg : rs_neg;
      end
      (de_branch_type == B_JUMP): begin
        act_taken  = 1'b1;
        act_target = j_target;
        act_uncond = 1'b1;
      end
      (de_branch_type == B_JREG): begin
        act_taken  = 1'b1;
        act_target = de_data_rs;
        act_uncond = 1'b1;
      end
      default: act_taken = 1'b0;
    endcase
  end

  assign mispredict = (act_taken != de_pred_taken)
    || (act_taken && de_pred_taken
        && (act_target != de_pred_target));
  assign correct_pc = act_taken ? act_target : de_pc + 32'd8;

  assign bht_cur  = bht[de_bidx];
  assign bht_next = act_taken
    ? ((bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'b01)
    : ((bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'h0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      btb_valid        <= '0;
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else begin
      redirect_valid <= qual && mispredict;
      if (qual) begin
        stat_branches <= stat_branches + CNT_W'(1);
        bht[de_bidx]  <= bht_next;
        if (mispredict) begin
          stat_mispredicts <= stat_mispredicts + CNT_W'(1);
          redirect_pc      <= correct_pc;
        end
        if (act_taken) btb_valid[de_tidx] <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset: it is only read behind btb_valid.
  always_ff @(posedge clk) begin
    if (qual && act_taken) begin
      btb_tag[de_tidx]    <= de_tag;
      btb_target[de_tidx] <= act_target;
      btb_uncond[de_tidx] <= act_uncond;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], de_instruction[31:28]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: scoreboard of redirect/stat
// expectations plus direct lookup checks.
module tb_branch_predict_unit;

  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_EQNE = 3'd1;
  localparam logic [2:0] B_LTGE = 3'd2;
  localparam logic [2:0] B_JUMP = 3'd3;
  localparam logic [2:0] B_JREG = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        de_en;
  logic [31:0] de_pc;
  logic [31:0] de_instruction;
  logic        de_is_branch;
  logic [2:0]  de_branch_type;
  logic [31:0] de_data_rs;
  logic [31:0] de_data_rt;
  logic        de_pred_taken;
  logic [31:0] de_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predict_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .de_en            (de_en),
    .de_pc            (de_pc),
    .de_instruction   (de_instruction),
    .de_is_branch     (de_is_branch),
    .de_branch_type   (de_branch_type),
    .de_data_rs       (de_data_rs),
    .de_data_rt       (de_data_rt),
    .de_pred_taken    (de_pred_taken),
    .de_pred_target   (de_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] nb;
    logic [31:0] nm;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_br    = 0;
  logic [31:0] m_mp    = 0;
  logic [31:0] m_rpc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic en,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [2:0] ty, input logic [31:0] rs,
                      input logic [31:0] rt, input logic pt,
                      input logic [31:0] ptgt, input logic mis,
                      input logic [31:0] cpc);
    exp_t e;
    de_en = en; de_is_branch = 1'b1; de_pc = pc;
    de_instruction = instr; de_branch_type = ty;
    de_data_rs = rs; de_data_rt = rt;
    de_pred_taken = pt; de_pred_target = ptgt;
    if (en) begin
      m_br++;
      if (mis) begin m_mp++; m_rpc = cpc; end
    end
    e.tag = tag; e.rv = en && mis; e.rpc = m_rpc;
    e.nb = m_br; e.nm = m_mp;
    sb.push_back(e);
    @(posedge clk); #1;
    de_en = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_rv"}, {31'h0, redirect_valid}, {31'h0, e.rv});
    chk({e.tag, "_rpc"}, redirect_pc, e.rpc);
    chk({e.tag, "_nb"}, stat_branches, e.nb);
    chk({e.tag, "_nm"}, stat_mispredicts, e.nm);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    if_pc = pc; #1;
    chk({tag, "_tk"}, {31'h0, if_pred_taken}, {31'h0, tk});
    chk({tag, "_tgt"}, if_pred_target, tgt);
  endtask

  logic [31:0] rsv [4];
  logic [3:0]  t_ltz, t_gez, t_lez, t_gtz;

  initial begin
    rst_n = 1'b0; if_pc = 0; de_en = 0; de_is_branch = 0;
    de_pc = 0; de_instruction = 0; de_branch_type = 0;
    de_data_rs = 0; de_data_rt = 0;
    de_pred_taken = 0; de_pred_target = 0;
    #1;
    chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_nb", stat_branches, 32'h0);
    chk("rst_nm", stat_mispredicts, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    look("cold", 32'h1000, 1'b0, 32'h0);

    step("beq", 1, 32'h1000, 32'h1000_0004, B_EQNE, 5, 5,
         0, 0, 1, 32'h1014);
    look("beq_lk", 32'h1000, 1'b1, 32'h1014);
    step("idle", 0, 0, 0, B_NONE, 0, 0, 0, 0, 0, 0);

    step("bne_tr", 1, 32'h2000, 32'h1400_000F, B_EQNE, 1, 2,
         0, 0, 1, 32'h2040);
    step("bne_ok", 1, 32'h2000, 32'h1400_000F, B_EQNE, 1, 2,
         1, 32'h2040, 0, 0);
    look("bne_lk", 32'h2000, 1'b1, 32'h2040);
    step("bne_nt", 1, 32'h2000, 32'h1400_000F, B_EQNE, 7, 7,
         1, 32'h2040, 1, 32'h2008);
    look("bne_lk2", 32'h2000, 1'b1, 32'h2040);
    for (int i = 0; i < 4; i++)
      step("sat_t", 1, 32'h2000, 32'h1400_000F, B_EQNE, 1, 2,
           1, 32'h2040, 0, 0);
    step("sat_nt", 1, 32'h2000, 32'h1400_000F, B_EQNE, 3, 3,
         1, 32'h2040, 1, 32'h2008);
    look("sat_lk", 32'h2000, 1'b1, 32'h2040);
    step("sat_nt2", 1, 32'h2000, 32'h1400_000F, B_EQNE, 3, 3,
         1, 32'h2040, 1, 32'h2008);
    look("weak_lk", 32'h2000, 1'b0, 32'h0);

    step("j1", 1, 32'h0040_0000, 32'h0800_0400, B_JUMP, 0, 0,
         0, 0, 1, 32'h0000_1000);
    step("j2", 1, 32'h0040_0000, 32'h0800_0400, B_JUMP, 0, 0,
         1, 32'h0000_1000, 0, 0);
    for (int i = 0; i < 3; i++)
      step("bht_dn", 1, 32'h1000, 32'h1000_0004, B_EQNE, 1, 2,
           0, 0, 0, 0);
    look("j_unc", 32'h0040_0000, 1'b1, 32'h0000_1000);
    look("alias", 32'h1000, 1'b0, 32'h0);

    step("jr1", 1, 32'h3004, 32'h0000_0008, B_JREG, 32'h8000_0100, 0,
         0, 0, 1, 32'h8000_0100);
    step("jr2", 1, 32'h3004, 32'h0000_0008, B_JREG, 32'h8000_0200, 0,
         1, 32'h8000_0100, 1, 32'h8000_0200);
    look("jr_lk", 32'h3004, 1'b1, 32'h8000_0200);

    rsv[0] = 32'h0; rsv[1] = 32'h1;
    rsv[2] = 32'hFFFF_FFFF; rsv[3] = 32'h8000_0000;
    t_ltz = 4'b1100; t_gez = 4'b0011;
    t_lez = 4'b1101; t_gtz = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step("bltz", 1, 32'h4008, 32'h0400_0001, B_LTGE, rsv[i], 0,
           0, 0, t_ltz[i], 32'h4010);
      step("bgez", 1, 32'h4008, 32'h0401_0001, B_LTGE, rsv[i], 0,
           0, 0, t_gez[i], 32'h4010);
      step("blez", 1, 32'h4008, 32'h1800_0001, B_EQNE, rsv[i], 0,
           0, 0, t_lez[i], 32'h4010);
      step("bgtz", 1, 32'h4008, 32'h1C00_0001, B_EQNE, rsv[i], 0,
           0, 0, t_gtz[i], 32'h4010);
    end

    step("en0", 0, 32'h500C, 32'h1000_0004, B_EQNE, 1, 1,
         0, 0, 1, 32'h5020);
    look("en0_lk", 32'h500C, 1'b0, 32'h0);
    step("other", 1, 32'h6010, 32'h0, B_NONE, 0, 0,
         1, 32'h6100, 1, 32'h6018);

    step("pre_rst", 1, 32'h1000, 32'h1000_0004, B_EQNE, 5, 5,
         0, 0, 1, 32'h1014);
    rst_n = 1'b0; #1;
    chk("mid_rv", {31'h0, redirect_valid}, 32'h0);
    chk("mid_rpc", redirect_pc, 32'h0);
    chk("mid_nb", stat_branches, 32'h0);
    chk("mid_nm", stat_mispredicts, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_br = 0; m_mp = 0; m_rpc = 0;
    look("post_jr", 32'h3004, 1'b0, 32'h0);
    look("post_j", 32'h0040_0000, 1'b0, 32'h0);
    step("post_beq", 1, 32'h1000, 32'h1000_0004, B_EQNE, 5, 5,
         0, 0, 1, 32'h1014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
